// File: rtl/rotate_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rotate_arbiter_pkg
// Description : Shared types, constants and round-robin picker for the
//               rotate arbiter.
// Revision    : 1.0
// ============================================================================
package rotate_arbiter_pkg;

    localparam int ROT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        left;
        logic [5:0]  shift;
    } operand_t;

    // First set bit at or above ptr, wrapping modulo nreq (nreq <= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int         nreq);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (i < nreq && !found && valid[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotate_arbiter_shift.sv
`default_nettype none
// ============================================================================
// Module      : rotate_arbiter_shift
// Description : Combinational 64-bit rotate, left or right by 0..63.
// Revision    : 1.0
// ============================================================================
module rotate_arbiter_shift
    import rotate_arbiter_pkg::*;
(
    input  logic [ROT_W-1:0] data,
    input  logic [5:0]       shift,
    input  logic             left,
    output logic [ROT_W-1:0] result
);

    logic [6:0] w_inv;

    assign w_inv = 7'(ROT_W) - {1'b0, shift};

    // A zero amount bypasses the shifters so no shift-by-64 term reaches the output.
    always_comb begin
        result = data;
        if (shift != 6'd0) begin
            if (left) begin
                result = (data << shift) | (data >> w_inv);
            end else begin
                result = (data >> shift) | (data << w_inv);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rotate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rotate_arbiter
// Description : Round-robin sharing of one 64-bit rotator between NREQ
//               requesters, with a valid/ready response channel.
// Revision    : 1.0
// ============================================================================
module rotate_arbiter
    import rotate_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]   req_left,
    input  logic [NREQ*6-1:0] req_shift,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ROT_W-1:0]  rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    localparam logic [IDW-1:0] c_last = IDW'(NREQ - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   w_grant;
    logic             w_any;
    operand_t         r_op;
    operand_t         w_op;
    logic [ROT_W-1:0] w_rot;

    assign w_any   = |req_valid;
    assign w_grant = IDW'(rr_pick(8'(req_valid), 3'(r_ptr), NREQ));
    assign busy    = (r_state != IDLE);

    always_comb begin
        w_op.a     = req_a[32*int'(w_grant) +: 32];
        w_op.b     = req_b[32*int'(w_grant) +: 32];
        w_op.left  = req_left[w_grant];
        w_op.shift = req_shift[6*int'(w_grant) +: 6];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt        = EXEC;
                    req_ready[w_grant] = 1'b1;
                end
            end
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_op      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op  <= w_op;
                        r_id  <= w_grant;
                        r_ptr <= (w_grant == c_last) ? '0 : w_grant + 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data  <= w_rot;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    rotate_arbiter_shift u_shift (
        .data   ({r_op.a, r_op.b}),
        .shift  (r_op.shift),
        .left   (r_op.left),
        .result (w_rot)
    );

endmodule
`default_nettype wire
